// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer: sweeps ADC channels 0..chan_last over SPI and writes {channel, sample} words to a FIFO.
// Optional feature: define ADC_SWEEP_TAG_EN to tag each word with a 13-bit sweep counter in out_data[31:19].
module adc_channel_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int CS_HIGH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  chan_last,
    input  logic        fifo_prog_full,
    input  logic        adc_sdo,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic        adc_sdi,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, GAP, SETUP, SHIFT, HOLD} state_t;

    localparam logic [7:0] DIV_TOP     = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_TOP     = 8'(CS_HIGH - 1);
    localparam logic [5:0] LAST_TOGGLE = 6'd32;

    state_t      state, state_nxt;
    logic [2:0]  chan, chan_nxt;
    logic [2:0]  sweep_last, sweep_last_nxt;
    logic [7:0]  gap_cnt, gap_cnt_nxt, gap_inc;
    logic [7:0]  div_cnt, div_cnt_nxt;
    logic [5:0]  tog_cnt, tog_cnt_nxt;
    logic [15:0] sample, sample_nxt;
    logic [15:0] cmd, cmd_nxt;
    logic        sclk_nxt, cs_n_nxt, sdi_nxt, valid_nxt;
    logic [31:0] data_nxt;
    logic [12:0] tag;

`ifdef ADC_SWEEP_TAG_EN
    logic [12:0] sweep_cnt, sweep_cnt_nxt;
    assign tag = sweep_cnt;
`else
    assign tag = 13'd0;
`endif

    assign busy = (state != IDLE);

    // gap_cnt holds the number of cycles adc_cs_n has already been high; saturates so long stalls are harmless
    assign gap_inc = (gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan       <= 3'd0;
            sweep_last <= 3'd0;
            gap_cnt    <= 8'd0;
            div_cnt    <= 8'd0;
            tog_cnt    <= 6'd0;
            sample     <= 16'd0;
            cmd        <= 16'd0;
            adc_sclk   <= 1'b0;
            adc_cs_n   <= 1'b1;
            adc_sdi    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
`ifdef ADC_SWEEP_TAG_EN
            sweep_cnt  <= 13'd0;
`endif
        end else begin
            chan       <= chan_nxt;
            sweep_last <= sweep_last_nxt;
            gap_cnt    <= gap_cnt_nxt;
            div_cnt    <= div_cnt_nxt;
            tog_cnt    <= tog_cnt_nxt;
            sample     <= sample_nxt;
            cmd        <= cmd_nxt;
            adc_sclk   <= sclk_nxt;
            adc_cs_n   <= cs_n_nxt;
            adc_sdi    <= sdi_nxt;
            out_valid  <= valid_nxt;
            out_data   <= data_nxt;
`ifdef ADC_SWEEP_TAG_EN
            sweep_cnt  <= sweep_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        chan_nxt       = chan;
        sweep_last_nxt = sweep_last;
        gap_cnt_nxt    = gap_cnt;
        div_cnt_nxt    = div_cnt;
        tog_cnt_nxt    = tog_cnt;
        sample_nxt     = sample;
        cmd_nxt        = cmd;
        sclk_nxt       = adc_sclk;
        cs_n_nxt       = adc_cs_n;
        sdi_nxt        = adc_sdi;
        valid_nxt      = 1'b0;
        data_nxt       = out_data;
`ifdef ADC_SWEEP_TAG_EN
        sweep_cnt_nxt  = sweep_cnt;
`endif

        case (state)
            IDLE: begin
                gap_cnt_nxt = gap_inc;
                if (start) begin
                    state_nxt      = GAP;
                    chan_nxt       = 3'd0;
                    sweep_last_nxt = chan_last;
                end
            end

            // A frame may begin only once the next cycle would complete the minimum chip-select high time
            GAP: begin
                if (!start) begin
                    state_nxt   = IDLE;
                    gap_cnt_nxt = gap_inc;
                end else if (gap_cnt >= GAP_TOP && !fifo_prog_full) begin
                    state_nxt   = SETUP;
                    cs_n_nxt    = 1'b0;
                    sdi_nxt     = chan[2];
                    cmd_nxt     = {chan[1:0], 14'd0};
                    div_cnt_nxt = 8'd0;
                    tog_cnt_nxt = 6'd0;
                end else begin
                    gap_cnt_nxt = gap_inc;
                end
            end

            SETUP: begin
                state_nxt   = SHIFT;
                div_cnt_nxt = div_cnt + 8'd1;
            end

            // Every CLK_DIV cycles: toggle SCLK for 32 half-periods, then one more half-period before releasing CS
            SHIFT: begin
                if (div_cnt == DIV_TOP) begin
                    div_cnt_nxt = 8'd0;
                    if (tog_cnt == LAST_TOGGLE) begin
                        state_nxt = HOLD;
                        cs_n_nxt  = 1'b1;
                        sdi_nxt   = 1'b0;
                        valid_nxt = 1'b1;
                        data_nxt  = {tag, chan, sample};
                    end else begin
                        sclk_nxt    = ~adc_sclk;
                        tog_cnt_nxt = tog_cnt + 6'd1;
                        if (!adc_sclk) begin
                            sample_nxt = {sample[14:0], adc_sdo};
                        end else begin
                            sdi_nxt = cmd[15];
                            cmd_nxt = {cmd[14:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end
            end

            HOLD: begin
                state_nxt   = GAP;
                gap_cnt_nxt = 8'd1;
                if (chan == sweep_last) begin
                    chan_nxt       = 3'd0;
                    sweep_last_nxt = chan_last;
`ifdef ADC_SWEEP_TAG_EN
                    sweep_cnt_nxt  = sweep_cnt + 13'd1;
`endif
                end else begin
                    chan_nxt = chan + 3'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// tb_adc_channel_sequencer: directed and randomized checks of adc_channel_sequencer against a sweep-level reference model.
// The ADC is modelled as a shift-out of a fresh random 16-bit word per frame.
module tb_adc_channel_sequencer;

    localparam int CLK_DIV = 4;
    localparam int CS_HIGH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  chan_last;
    logic        fifo_prog_full;
    logic        adc_sdo = 1'b0;
    logic        adc_sclk, adc_cs_n, adc_sdi, out_valid, busy;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_channel_sequencer #(.CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .chan_last      (chan_last),
        .fifo_prog_full (fifo_prog_full),
        .adc_sdo        (adc_sdo),
        .adc_sclk       (adc_sclk),
        .adc_cs_n       (adc_cs_n),
        .adc_sdi        (adc_sdi),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .busy           (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [15:0] word;
        logic [15:0] cmd;
        int          low_len;
        int          rises;
        logic        cs_rose;
        logic [2:0]  last_at_emit;
    } frame_t;

    frame_t      frames[$];
    int          exp_q[$];
    int          exp_tag = 0;
    int          cyc = 0;
    int          falls = 0;
    int          valids = 0;
    int          dbl_valid = 0;
    int          hold_viol = 0;
    int          rises_now = 0;
    int          first_fall_cyc = -1;
    int          low_start = 0;
    int          bit_idx = 0;
    logic        prev_cs_n = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic [15:0] word = 16'd0;
    logic [15:0] cmd = 16'd0;
    bit          fixed_sdo = 1'b0;

    // ADC model and bus monitor: serves a word per frame, captures the command and each emitted FIFO word
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_cs_n  = 1'b1;
            prev_sclk  = 1'b0;
            prev_valid = 1'b0;
            prev_data  = 32'd0;
            rises_now  = 0;
        end else begin
            if (prev_cs_n && !adc_cs_n) begin
                word      = fixed_sdo ? 16'hA5C3 : 16'($urandom);
                bit_idx   = 15;
                adc_sdo   = word[15];
                cmd       = 16'd0;
                low_start = cyc;
                rises_now = 0;
                falls++;
                if (first_fall_cyc < 0) first_fall_cyc = cyc;
            end
            if (!adc_cs_n && !prev_sclk && adc_sclk) begin
                cmd = {cmd[14:0], adc_sdi};
                rises_now++;
            end
            if (!adc_cs_n && prev_sclk && !adc_sclk && bit_idx > 0) begin
                bit_idx--;
                adc_sdo = word[bit_idx];
            end
            if (out_valid) begin
                valids++;
                if (prev_valid) dbl_valid++;
                frames.push_back('{out_data, word, cmd, cyc - low_start, rises_now,
                                   (!prev_cs_n && adc_cs_n), chan_last});
            end else if (out_data !== prev_data) begin
                hold_viol++;
            end
            prev_cs_n  = adc_cs_n;
            prev_sclk  = adc_sclk;
            prev_valid = out_valid;
            prev_data  = out_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] cl, input logic full);
        @(posedge clk);
        #2;
        start          = s;
        chan_last      = cl;
        fifo_prog_full = full;
    endtask

    task automatic fillSweep(input int last);
        exp_q.delete();
        for (int i = 0; i <= last; i++) exp_q.push_back(i);
    endtask

    task automatic waitFrames(input int n, input int budget, input string tag);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        checkOutput(tag, 32'(frames.size() >= n), 32'd1);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    // Reference model: channels run 0..last per sweep; the last used for a new sweep is the one seen when the previous sweep ended
    task automatic checkFrame(input string tag);
        frame_t      f;
        int          ch;
        logic [12:0] tag13;
        if (frames.size() == 0) begin
            checkOutput({tag, "_present"}, 32'd0, 32'd1);
            return;
        end
        f  = frames.pop_front();
        ch = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
`ifdef ADC_SWEEP_TAG_EN
        tag13 = 13'(exp_tag);
`else
        tag13 = 13'd0;
`endif
        checkOutput({tag, "_data"}, f.data, {tag13, 3'(ch), f.word});
        checkOutput({tag, "_cmd"}, 32'(f.cmd), 32'({3'(ch), 13'd0}));
        checkOutput({tag, "_cslow"}, 32'(f.low_len), 32'(33 * CLK_DIV));
        checkOutput({tag, "_rises"}, 32'(f.rises), 32'd16);
        checkOutput({tag, "_csrise"}, 32'(f.cs_rose), 32'd1);
        if (exp_q.size() == 0) begin
            fillSweep(int'(f.last_at_emit));
            exp_tag = (exp_tag + 1) % 8192;
        end
    endtask

    initial begin
        int rel_cyc;
        int k;
        int v0;
        int f0;

        rst            = 1'b1;
        start          = 1'b0;
        chan_last      = 3'd0;
        fifo_prog_full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_cs_n", 32'(adc_cs_n), 32'd1);
        checkOutput("rst_sclk", 32'(adc_sclk), 32'd0);
        checkOutput("rst_sdi", 32'(adc_sdi), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", out_data, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // Fixed A5C3 sweep over channels 0..2 starting straight out of reset
        fixed_sdo = 1'b1;
        applyStimulus(1'b1, 3'd2, 1'b0);
        fillSweep(2);
        exp_tag = 0;
        first_fall_cyc = -1;
        @(posedge clk);
        #2;
        rst     = 1'b0;
        rel_cyc = cyc + 1;
        waitFrames(4, 1000, "sweep_wait");
        checkOutput("first_fall_gap", 32'((first_fall_cyc - rel_cyc) >= CS_HIGH), 32'd1);
        for (int i = 0; i < 4; i++) checkFrame($sformatf("sweep%0d", i));
        fixed_sdo = 1'b0;

        // FIFO full raised mid-frame: frame still emitted, then stall in GAP
        k = 0;
        while (adc_cs_n && k < 100) begin @(posedge clk); #1; k++; end
        applyStimulus(1'b1, 3'd2, 1'b1);
        waitFrames(1, 300, "full_midframe_wait");
        checkFrame("full_midframe");
        v0 = valids;
        f0 = falls;
        repeat (500) @(posedge clk);
        #1;
        checkOutput("stall_cs_high", 32'(adc_cs_n), 32'd1);
        checkOutput("stall_no_valid", 32'(valids - v0), 32'd0);
        checkOutput("stall_no_fall", 32'(falls - f0), 32'd0);
        checkOutput("stall_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 3'd2, 1'b0);
        k = 0;
        while (adc_cs_n && k < 50) begin @(posedge clk); #1; k++; end
        checkOutput("stall_release", 32'(k <= CS_HIGH + 1), 32'd1);

        // start dropped at frame midpoint
        repeat (66) @(posedge clk);
        v0 = valids;
        f0 = falls;
        applyStimulus(1'b0, 3'd2, 1'b0);
        repeat (400) @(posedge clk);
        #1;
        checkOutput("stop_one_valid", 32'(valids - v0), 32'd1);
        checkOutput("stop_busy", 32'(busy), 32'd0);
        checkOutput("stop_cs_high", 32'(adc_cs_n), 32'd1);
        checkOutput("stop_no_fall", 32'(falls - f0), 32'd0);
        checkFrame("stop_frame");

        // Reset pulsed at the 16th SCLK rise
        applyStimulus(1'b1, 3'd5, 1'b0);
        fillSweep(5);
        k = 0;
        while (!(rises_now == 16 && !adc_cs_n) && k < 400) begin @(negedge clk); #1; k++; end
        checkOutput("rst16_found", 32'(k < 400), 32'd1);
        v0 = valids;
        rst = 1'b1;
        #1;
        checkOutput("rst16_cs_n", 32'(adc_cs_n), 32'd1);
        checkOutput("rst16_sclk", 32'(adc_sclk), 32'd0);
        checkOutput("rst16_sdi", 32'(adc_sdi), 32'd0);
        checkOutput("rst16_valid", 32'(out_valid), 32'd0);
        checkOutput("rst16_data", out_data, 32'd0);
        checkOutput("rst16_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        checkOutput("rst16_no_valid", 32'(valids - v0), 32'd0);
        checkOutput("rst16_no_frame", 32'(frames.size()), 32'd0);
        fillSweep(5);
        exp_tag = 0;
        waitFrames(2, 700, "rst16_restart_wait");
        checkFrame("rst16_restart0");
        checkFrame("rst16_restart1");
        applyStimulus(1'b0, 3'd5, 1'b0);
        waitIdle(600, "rst16_idle");
        while (frames.size() > 0) checkFrame("rst16_drain");

        // chan_last 7 -> 1 while channel 3 is being read
        applyStimulus(1'b1, 3'd7, 1'b0);
        fillSweep(7);
        waitFrames(3, 1000, "cl_first3");
        k = 0;
        while (adc_cs_n && k < 100) begin @(posedge clk); #1; k++; end
        applyStimulus(1'b1, 3'd1, 1'b0);
        waitFrames(11, 2000, "cl_wait");
        for (int i = 0; i < 11; i++) checkFrame($sformatf("cl%0d", i));

        // Random chan_last / FIFO-full activity while sweeping
        for (int r = 0; r < 6; r++) begin
            int waitc;
            waitc = $urandom_range(400, 60);
            applyStimulus(1'b1, 3'($urandom_range(7, 0)), ($urandom_range(3, 0) == 0));
            repeat (waitc) @(posedge clk);
        end
        applyStimulus(1'b0, chan_last, 1'b0);
        waitIdle(600, "rand_idle");
        while (frames.size() > 0) checkFrame("rand");

        checkOutput("no_double_valid", 32'(dbl_valid), 32'd0);
        checkOutput("data_hold", 32'(hold_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_channel_sequencer.md
ADC_CHANNEL_SEQUENCER -- requirements
Module: adc_channel_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 2..255.
REQ-002 Parameter CS_HIGH, default 8: minimum adc_cs_n high time between frames in clk cycles, legal range 1..255.
REQ-003 clk  input  1: single clock; all logic rising-edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 start  input  1: level; high = run continuous channel sweeps.
REQ-006 chan_last  input  3: highest channel index in a sweep (0..7).
REQ-007 fifo_prog_full  input  1: downstream pipe-out FIFO programmable-full.
REQ-008 adc_sdo  input  1: ADC serial data out.
REQ-009 adc_sclk  output  1: ADC serial clock, idle low.
REQ-010 adc_cs_n  output  1: ADC chip select, active low.
REQ-011 adc_sdi  output  1: ADC serial data in (channel command).
REQ-012 out_data  output  32: [31:16] channel number, [15:0] sample.
REQ-013 out_valid  output  1: one-cycle FIFO write strobe for out_data.
REQ-014 busy  output  1: high whenever state is not IDLE.

Function
REQ-015 States: IDLE, GAP, SETUP, SHIFT, HOLD; busy = (state != IDLE).
REQ-016 IDLE -> GAP when start=1; channel counter loads 0, chan_last latched into sweep_last.
REQ-017 GAP: adc_cs_n=1; leaves to SETUP only when CS_HIGH cycles have elapsed since adc_cs_n rose and fifo_prog_full=0.
REQ-018 GAP -> IDLE when start=0 (checked before any new frame begins).
REQ-019 SETUP entry cycle T: adc_cs_n falls; adc_sdi drives command bit 15.
REQ-020 Command word = {channel[2:0], 13'b0}, shifted MSB first; adc_sdi updates only on adc_sclk falling transitions (and at T).
REQ-021 SHIFT: adc_sclk toggles every CLK_DIV cycles, first rise at T+CLK_DIV, 16 rising edges, last fall at T+32*CLK_DIV.
REQ-022 adc_sdo sampled in the clk cycle adc_sclk transitions 0->1; shift register MSB first; 16 samples.
REQ-023 HOLD: adc_cs_n rises at T+33*CLK_DIV; in that same cycle out_valid=1 and out_data = {13'b0, channel, sample}.
REQ-024 out_data holds its value until the next out_valid; out_valid never high two consecutive cycles.
REQ-025 After HOLD: channel = (channel == sweep_last) ? 0 : channel+1; on wrap to 0, chan_last re-latched into sweep_last; state -> GAP.
REQ-026 start deasserted mid-frame: frame completes and is emitted, then GAP -> IDLE.
REQ-027 fifo_prog_full asserted mid-frame: frame completes and is emitted; stall applies only at GAP.
REQ-028 chan_last changes mid-sweep have no effect until the next wrap.
REQ-029 sweep_last=0: every frame reads channel 0.

Reset
REQ-030 rst=1 forces immediately, regardless of clk: state IDLE, adc_cs_n=1, adc_sclk=0, adc_sdi=0, out_valid=0, out_data=0, busy=0, channel=0, counters=0.
REQ-031 Reset mid-frame aborts the frame with no out_valid; after release, operation restarts from IDLE.
REQ-032 First adc_cs_n fall after reset release with start=1 occurs no earlier than CS_HIGH cycles after release.

Configuration
REQ-033 Macro ADC_SWEEP_TAG_EN defined: out_data[31:19] = 13-bit sweep counter (reset 0, increments on each channel wrap, wraps 8191->0), [18:16] = channel.
REQ-034 ADC_SWEEP_TAG_EN undefined: out_data[31:19] = 0; no sweep counter logic.

Verification
REQ-035 CLK_DIV=4, SDO model returns 16'hA5C3, chan_last=2, start=1 -> out_data 0x0000A5C3, 0x0001A5C3, 0x0002A5C3, 0x0000A5C3 in order; adc_cs_n low 132 cycles per frame; SDI words 0x0000, 0x2000, 0x4000.
REQ-036 fifo_prog_full=1 during GAP for 500 cycles -> adc_cs_n stays high, no out_valid; first frame starts within CS_HIGH+1 cycles of prog_full dropping.
REQ-037 start dropped at frame midpoint -> exactly one further out_valid, then busy=0 and adc_cs_n stays high.
REQ-038 rst pulsed at 16th SCLK rise -> all outputs at reset values same cycle, no out_valid; restart emits channel 0 first.
REQ-039 chan_last changed 7->1 while reading channel 3 -> channels 4,5,6,7 follow, then 0,1,0,1.
REQ-040 ADC_SWEEP_TAG_EN defined, chan_last=0 -> out_data[31:19] counts 0,1,2,... per frame; undefined -> bits stay 0.
